// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//    Shares one single-port framebuffer between the VGA scan-out and a writer.
//    Each 12-bit framebuffer word holds four 3-bit pixels.
//    Scan-out fetches one word every 16 pixel clocks on active lines.
//    Every framebuffer pixel covers 4x4 screen pixels.
//    Scan reads always win; the writer gets every other free cycle at most.
//
// Ports
//    clk, rst_n          pixel clock, asynchronous active-low reset
//    hcount, vcount      raster position from the external timing generator
//    wr_req/addr/data    writer request (held until wr_ack)
//    wr_ack              one-cycle accept pulse, coincident with mem_we
//    mem_en/we/addr/wdata registered framebuffer strobes
//    mem_rdata           framebuffer read data (one cycle read latency)
//    pix_rgb             {r,g,b} of the current pixel, 0 outside active area
//    wr_oob              sticky: an out-of-range write was accepted
// ---------------------------------------------------------------------------
module vga_fb_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic        wr_req,
   input  logic [14:0] wr_addr,
   input  logic [11:0] wr_data,
   output logic        wr_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [11:0] mem_wdata,
   input  logic [11:0] mem_rdata,
   output logic [2:0]  pix_rgb,
   output logic        wr_oob
);

   localparam logic [14:0] LAST_ADDR = 15'd20249;

   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [14:0] mem_addr_q, mem_addr_d;
   logic [11:0] mem_wdata_q, mem_wdata_d;
   logic        wr_oob_q, wr_oob_d;
   logic        rd_valid_q, rd_valid_d;
   logic [11:0] word_q, word_d;

   logic        line_active;
   logic        scan_slot;
   logic        pix_active;
   logic        grant;
   logic [10:0] slot_off;
   logic [9:0]  v_off;
   logic [14:0] scan_addr;

   assign line_active = (vcount >= 10'd31) && (vcount <= 10'd930);
   assign slot_off    = hcount - 11'd381;
   // Slots sit at 381+16k, i.e. hcount[3:0] == 13, for k = 0..89.
   assign scan_slot   = line_active && (hcount >= 11'd381) && (hcount <= 11'd1805)
                        && (hcount[3:0] == 4'd13);
   assign v_off       = vcount - 10'd31;
   // row*90 + k; maximum 224*90+89 = 20249, no overflow in 15 bits.
   assign scan_addr   = ({5'd0, v_off >> 2} * 15'd90) + {4'd0, slot_off >> 4};
   assign pix_active  = line_active && (hcount >= 11'd384) && (hcount <= 11'd1823);
   assign grant       = (state_q == ST_IDLE) && wr_req && !scan_slot;

   always_comb begin
      state_d     = ST_IDLE;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      wr_oob_d    = wr_oob_q;
      // Read data is valid in the cycle after a read was presented.
      rd_valid_d  = mem_en_q && !mem_we_q;
      word_d      = rd_valid_q ? mem_rdata : word_q;

      if (scan_slot) begin
         mem_en_d   = 1'b1;
         mem_addr_d = scan_addr;
      end else if (grant) begin
         state_d = ST_ACK;
         if (wr_addr <= LAST_ADDR) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
         end else begin
            // Acked but dropped: the strobes stay low.
            wr_oob_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 15'd0;
         mem_wdata_q <= 12'd0;
         wr_oob_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         word_q      <= 12'd0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         wr_oob_q    <= wr_oob_d;
         rd_valid_q  <= rd_valid_d;
         word_q      <= word_d;
      end
   end

   // Pixel 0 lives in the top field; 384 is a multiple of 16.
   // So hcount[3:2] selects the field directly.
   always_comb begin
      pix_rgb = 3'd0;
      if (pix_active) begin
         case (hcount[3:2])
            2'd0:    pix_rgb = word_q[11:9];
            2'd1:    pix_rgb = word_q[8:6];
            2'd2:    pix_rgb = word_q[5:3];
            default: pix_rgb = word_q[2:0];
         endcase
      end
   end

   assign wr_ack    = (state_q == ST_ACK);
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign wr_oob    = wr_oob_q;

endmodule
